// File: rtl/ftdi_chip_fifo_model.sv
// Cycle-level model of an FTDI 245 synchronous-FIFO chip (FT232H/FT600/FT601) with real
// RX/TX buffers, a host-side stream port, a sticky protocol monitor and traffic counters.
module ftdi_chip_fifo_model #(
   parameter  int unsigned CHIP_EW    = 0,
   parameter  int unsigned RX_AW      = 6,
   parameter  int unsigned TX_AW      = 6,
   parameter  int unsigned TXE_MARGIN = 0,
   localparam int unsigned DW         = 8 << CHIP_EW,
   localparam int unsigned BW         = 1 << CHIP_EW
) (
   input  logic          ftdi_clk,
   input  logic          rst,
   output logic          ftdi_rxf_n,
   output logic          ftdi_txe_n,
   input  logic          ftdi_oe_n,
   input  logic          ftdi_rd_n,
   input  logic          ftdi_wr_n,
   inout  wire  [DW-1:0] ftdi_data,
   inout  wire  [BW-1:0] ftdi_be,
   input  logic          host_in_valid,
   output logic          host_in_ready,
   input  logic [DW-1:0] host_in_data,
   input  logic [BW-1:0] host_in_be,
   output logic          host_out_valid,
   input  logic          host_out_ready,
   output logic [DW-1:0] host_out_data,
   output logic [BW-1:0] host_out_be,
   output logic          protocol_err,
   output logic [31:0]   rx_word_cnt,
   output logic [31:0]   tx_byte_cnt
);
   localparam int unsigned RX_DEPTH   = 1 << RX_AW;
   localparam int unsigned TX_DEPTH   = 1 << TX_AW;
   localparam int unsigned RCW        = RX_AW + 1;
   localparam int unsigned TCW        = TX_AW + 1;
   localparam int unsigned TXE_THRESH = TX_DEPTH - 1 - TXE_MARGIN;

   logic [DW-1:0]    rx_data_q [RX_DEPTH];
   logic [BW-1:0]    rx_be_q   [RX_DEPTH];
   logic [DW-1:0]    tx_data_q [TX_DEPTH];
   logic [BW-1:0]    tx_be_q   [TX_DEPTH];

   logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [RCW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [TCW-1:0]   tx_cnt_q, tx_cnt_d;
   logic             rxf_n_q, rxf_n_d;
   logic             txe_n_q, txe_n_d;
   logic             err_q, err_d;
   logic [31:0]      rx_word_cnt_q, rx_word_cnt_d;
   logic [31:0]      tx_byte_cnt_q, tx_byte_cnt_d;

   logic             rx_pop, rx_store, tx_wr, tx_store, tx_drain, bus_drive;
   logic [BW-1:0]    rx_be_in, tx_be_in, rx_head_be;
   logic [DW-1:0]    rx_head_data;
   logic [31:0]      tx_be_bytes;

   // Handshakes, occupancy and next-state for both buffers, flags and counters
   always_comb begin
      rx_be_in      = (CHIP_EW == 0) ? '1 : host_in_be;
      tx_be_in      = (CHIP_EW == 0) ? '1 : ftdi_be;

      rx_pop        = ~rst & ~ftdi_rd_n & ~rxf_n_q;
      // A pop in the same cycle frees a slot, so a full buffer keeps streaming.
      host_in_ready = ~rst & ((rx_cnt_q < RCW'(RX_DEPTH)) | rx_pop);
      rx_store      = host_in_valid & host_in_ready & ((CHIP_EW == 0) | (host_in_be != '0));

      tx_wr         = ~rst & ~ftdi_wr_n & ~txe_n_q;
      tx_store      = tx_wr & ((CHIP_EW == 0) | (ftdi_be != '0));
      tx_drain      = ~rst & (tx_cnt_q != '0) & host_out_ready;

      tx_be_bytes   = '0;
      for (int unsigned i = 0; i < BW; i++) begin
         tx_be_bytes = tx_be_bytes + 32'(tx_be_in[i]);
      end

      rx_wp_d       = rx_store ? rx_wp_q + RX_AW'(1) : rx_wp_q;
      rx_rp_d       = rx_pop   ? rx_rp_q + RX_AW'(1) : rx_rp_q;
      rx_cnt_d      = rx_cnt_q + RCW'(rx_store) - RCW'(rx_pop);
      tx_wp_d       = tx_store ? tx_wp_q + TX_AW'(1) : tx_wp_q;
      tx_rp_d       = tx_drain ? tx_rp_q + TX_AW'(1) : tx_rp_q;
      tx_cnt_d      = tx_cnt_q + TCW'(tx_store) - TCW'(tx_drain);

      rxf_n_d       = (rx_cnt_d == '0);
      txe_n_d       = (tx_cnt_d > TCW'(TXE_THRESH));

      err_d         = err_q | (~ftdi_rd_n & ftdi_oe_n) | (~ftdi_rd_n & ~ftdi_wr_n)
                            | (~ftdi_wr_n & ~ftdi_oe_n);
      rx_word_cnt_d = rx_word_cnt_q + 32'(rx_pop);
      tx_byte_cnt_d = tx_byte_cnt_q + (tx_store ? tx_be_bytes : 32'd0);

      bus_drive     = ~rst & ~ftdi_oe_n;
      rx_head_data  = (rx_cnt_q != '0) ? rx_data_q[rx_rp_q] : '0;
      rx_head_be    = (CHIP_EW == 0) ? '1 : ((rx_cnt_q != '0) ? rx_be_q[rx_rp_q] : '0);
   end

   // Control state
   always_ff @(posedge ftdi_clk) begin
      if (rst) begin
         rx_wp_q       <= '0;
         rx_rp_q       <= '0;
         rx_cnt_q      <= '0;
         tx_wp_q       <= '0;
         tx_rp_q       <= '0;
         tx_cnt_q      <= '0;
         rxf_n_q       <= 1'b1;
         txe_n_q       <= 1'b1;
         err_q         <= 1'b0;
         rx_word_cnt_q <= '0;
         tx_byte_cnt_q <= '0;
      end else begin
         rx_wp_q       <= rx_wp_d;
         rx_rp_q       <= rx_rp_d;
         rx_cnt_q      <= rx_cnt_d;
         tx_wp_q       <= tx_wp_d;
         tx_rp_q       <= tx_rp_d;
         tx_cnt_q      <= tx_cnt_d;
         rxf_n_q       <= rxf_n_d;
         txe_n_q       <= txe_n_d;
         err_q         <= err_d;
         rx_word_cnt_q <= rx_word_cnt_d;
         tx_byte_cnt_q <= tx_byte_cnt_d;
      end
   end

   // Buffer storage; contents are don't-care outside the occupied window
   always_ff @(posedge ftdi_clk) begin
      if (rx_store) begin
         rx_data_q[rx_wp_q] <= host_in_data;
         rx_be_q[rx_wp_q]   <= rx_be_in;
      end
      if (tx_store) begin
         tx_data_q[tx_wp_q] <= ftdi_data;
         tx_be_q[tx_wp_q]   <= tx_be_in;
      end
   end

   assign ftdi_data      = bus_drive ? rx_head_data : {DW{1'bz}};
   assign ftdi_be        = bus_drive ? rx_head_be   : {BW{1'bz}};
   assign ftdi_rxf_n     = rxf_n_q;
   assign ftdi_txe_n     = txe_n_q;
   assign host_out_valid = (tx_cnt_q != '0);
   assign host_out_data  = tx_data_q[tx_rp_q];
   assign host_out_be    = tx_be_q[tx_rp_q];
   assign protocol_err   = err_q;
   assign rx_word_cnt    = rx_word_cnt_q;
   assign tx_byte_cnt    = tx_byte_cnt_q;

endmodule

// File: tb/tb_ftdi_chip_fifo_model.sv
// Bench for ftdi_chip_fifo_model: an 8-bit small-buffer instance for directed corner cases
// and a 32-bit instance for byte-enable cases plus randomized traffic against a queue model.
module tb_ftdi_chip_fifo_model;
   localparam int RXD_B  = 8;
   localparam int TXD_B  = 8;
   localparam int MARG_B = 2;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;

   // ---------------- instance A: CHIP_EW=0, depth 4/4, margin 0
   logic        rst_a, oe_a, rd_a, wr_a, hiv_a, hor_a;
   logic [7:0]  tbd_a, hid_a;
   logic [0:0]  tbbe_a, hib_a;
   wire  [7:0]  data_a;
   wire  [0:0]  be_a;
   logic        rxf_a, txe_a, hir_a, hov_a, err_a;
   logic [7:0]  hod_a;
   logic [0:0]  hob_a;
   logic [31:0] rxc_a, txc_a;
   assign data_a = oe_a ? tbd_a  : 'z;
   assign be_a   = oe_a ? tbbe_a : 'z;

   ftdi_chip_fifo_model #(.CHIP_EW(0), .RX_AW(2), .TX_AW(2), .TXE_MARGIN(0)) dut_a (
      .ftdi_clk(clk), .rst(rst_a), .ftdi_rxf_n(rxf_a), .ftdi_txe_n(txe_a),
      .ftdi_oe_n(oe_a), .ftdi_rd_n(rd_a), .ftdi_wr_n(wr_a),
      .ftdi_data(data_a), .ftdi_be(be_a),
      .host_in_valid(hiv_a), .host_in_ready(hir_a), .host_in_data(hid_a), .host_in_be(hib_a),
      .host_out_valid(hov_a), .host_out_ready(hor_a), .host_out_data(hod_a), .host_out_be(hob_a),
      .protocol_err(err_a), .rx_word_cnt(rxc_a), .tx_byte_cnt(txc_a));

   // ---------------- instance B: CHIP_EW=2, depth 8/8, margin 2
   logic        rst_b, oe_b, rd_b, wr_b, hiv_b, hor_b;
   logic [31:0] tbd_b, hid_b;
   logic [3:0]  tbbe_b, hib_b;
   wire  [31:0] data_b;
   wire  [3:0]  be_b;
   logic        rxf_b, txe_b, hir_b, hov_b, err_b;
   logic [31:0] hod_b;
   logic [3:0]  hob_b;
   logic [31:0] rxc_b, txc_b;
   assign data_b = oe_b ? tbd_b  : 'z;
   assign be_b   = oe_b ? tbbe_b : 'z;

   ftdi_chip_fifo_model #(.CHIP_EW(2), .RX_AW(3), .TX_AW(3), .TXE_MARGIN(MARG_B)) dut_b (
      .ftdi_clk(clk), .rst(rst_b), .ftdi_rxf_n(rxf_b), .ftdi_txe_n(txe_b),
      .ftdi_oe_n(oe_b), .ftdi_rd_n(rd_b), .ftdi_wr_n(wr_b),
      .ftdi_data(data_b), .ftdi_be(be_b),
      .host_in_valid(hiv_b), .host_in_ready(hir_b), .host_in_data(hid_b), .host_in_be(hib_b),
      .host_out_valid(hov_b), .host_out_ready(hor_b), .host_out_data(hod_b), .host_out_be(hob_b),
      .protocol_err(err_b), .rx_word_cnt(rxc_b), .tx_byte_cnt(txc_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // TX table vectors for instance A
   typedef struct {
      logic       wr_n;
      logic       rdy;
      logic [7:0] d;
      logic       exp_txe;
      logic       exp_ov;
      logic [7:0] exp_hd;
      int         exp_bytes;
   } tx_vec_t;
   tx_vec_t tv [9];

   // Reference model for instance B
   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  be;
   } word_t;
   word_t       rxq [$];
   word_t       txq [$];
   word_t       tmp;
   logic        rxf_m, txe_m, err_m, pop_m, rdy_m;
   int unsigned rxc_m, txc_m;

   logic [2:0]  epat [5];
   logic        eexp [5];

   initial begin
      n_pass  = 0;
      n_total = 0;
      tv[0] = '{1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 8'hA0, 1};
      tv[1] = '{1'b0, 1'b0, 8'hA1, 1'b0, 1'b1, 8'hA0, 2};
      tv[2] = '{1'b0, 1'b0, 8'hA2, 1'b0, 1'b1, 8'hA0, 3};
      tv[3] = '{1'b0, 1'b0, 8'hA3, 1'b1, 1'b1, 8'hA0, 4};
      tv[4] = '{1'b0, 1'b0, 8'hA4, 1'b1, 1'b1, 8'hA0, 4};
      tv[5] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA1, 4};
      tv[6] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA2, 4};
      tv[7] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA3, 4};
      tv[8] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 4};
      // {oe_n, rd_n, wr_n} and whether protocol_err must be raised
      epat[0] = 3'b101; eexp[0] = 1'b1;
      epat[1] = 3'b010; eexp[1] = 1'b1;
      epat[2] = 3'b000; eexp[2] = 1'b1;
      epat[3] = 3'b001; eexp[3] = 1'b0;
      epat[4] = 3'b110; eexp[4] = 1'b0;

      rst_a = 1'b1; oe_a = 1'b1; rd_a = 1'b1; wr_a = 1'b1; hiv_a = 1'b0; hor_a = 1'b0;
      tbd_a = '0; tbbe_a = '0; hid_a = '0; hib_a = '0;
      rst_b = 1'b1; oe_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; hiv_b = 1'b0; hor_b = 1'b0;
      tbd_b = '0; tbbe_b = '0; hid_b = '0; hib_b = '0;

      // ---- reset state
      tick();
      tick();
      chk("reset rxf_n", 32'(rxf_a), 32'd1);
      chk("reset txe_n", 32'(txe_a), 32'd1);
      chk("reset in_ready", 32'(hir_a), 32'd0);
      chk("reset out_valid", 32'(hov_a), 32'd0);
      chk("reset err", 32'(err_a), 32'd0);
      chk("reset rx_cnt", rxc_a, 32'd0);
      chk("reset tx_cnt", txc_a, 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();
      chk("txe_n after reset release", 32'(txe_a), 32'd0);

      // ---- RX: inject 01..04, then FPGA reads them back
      #1;
      chk("rx ready empty", 32'(hir_a), 32'd1);
      for (int i = 0; i < 4; i++) begin
         hiv_a = 1'b1;
         hid_a = 8'(i + 1);
         tick();
         chk("rx rxf_n after push", 32'(rxf_a), 32'd0);
      end
      hiv_a = 1'b0;
      #1;
      chk("rx ready when full", 32'(hir_a), 32'd0);
      oe_a = 1'b0;
      rd_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rx bus data", 32'(data_a), 32'(i + 1));
         tick();
         chk("rx rxf_n after pop", 32'(rxf_a), (i == 3) ? 32'd1 : 32'd0);
      end
      #1;
      chk("rx bus zero when empty", 32'(data_a), 32'd0);
      chk("rx word count", rxc_a, 32'd4);
      oe_a = 1'b1;
      rd_a = 1'b1;
      tick();

      // ---- RX full with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         hiv_a = 1'b1;
         hid_a = 8'(8'h10 + i);
         tick();
      end
      oe_a = 1'b0;
      rd_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         hid_a = 8'(8'h14 + i);
         #1;
         chk("full ready with pop", 32'(hir_a), 32'd1);
         chk("full stream data", 32'(data_a), 32'(8'h10 + i));
         tick();
         chk("full stream rxf_n", 32'(rxf_a), 32'd0);
      end
      hiv_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("full drain data", 32'(data_a), 32'(8'h1A + i));
         tick();
      end
      chk("full drained rxf_n", 32'(rxf_a), 32'd1);
      chk("full rx word count", rxc_a, 32'd18);
      oe_a = 1'b1;
      rd_a = 1'b1;
      tick();

      // ---- TX table: fill to full, ignored write, drain in order
      for (int k = 0; k < 9; k++) begin
         wr_a   = tv[k].wr_n;
         tbd_a  = tv[k].d;
         tbbe_a = 1'b0;
         hor_a  = tv[k].rdy;
         tick();
         chk("tx txe_n", 32'(txe_a), 32'(tv[k].exp_txe));
         chk("tx out_valid", 32'(hov_a), 32'(tv[k].exp_ov));
         if (tv[k].exp_ov) begin
            chk("tx head data", 32'(hod_a), 32'(tv[k].exp_hd));
            chk("tx head be", 32'(hob_a), 32'd1);
         end
         chk("tx byte count", txc_a, 32'(tv[k].exp_bytes));
      end
      wr_a  = 1'b1;
      hor_a = 1'b0;

      // ---- reset with 3 RX and 2 TX words buffered
      hiv_a = 1'b1; hid_a = 8'h31; wr_a = 1'b0; tbd_a = 8'hB0;
      tick();
      hid_a = 8'h32; tbd_a = 8'hB1;
      tick();
      wr_a = 1'b1; hid_a = 8'h33;
      tick();
      hiv_a = 1'b0;
      chk("pre-reset rxf_n", 32'(rxf_a), 32'd0);
      chk("pre-reset out_valid", 32'(hov_a), 32'd1);
      chk("pre-reset head", 32'(hod_a), 32'hB0);
      rst_a = 1'b1; oe_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0; hiv_a = 1'b1; hid_a = 8'h99;
      #1;
      chk("in_ready during reset", 32'(hir_a), 32'd0);
      tick();
      chk("mid reset rxf_n", 32'(rxf_a), 32'd1);
      chk("mid reset txe_n", 32'(txe_a), 32'd1);
      chk("mid reset out_valid", 32'(hov_a), 32'd0);
      tick();
      chk("held reset txe_n", 32'(txe_a), 32'd1);
      rst_a = 1'b0; oe_a = 1'b1; rd_a = 1'b1; wr_a = 1'b1; hiv_a = 1'b0; tbd_a = 8'h5A;
      tick();
      chk("post reset txe_n", 32'(txe_a), 32'd0);
      chk("post reset rxf_n", 32'(rxf_a), 32'd1);
      chk("post reset out_valid", 32'(hov_a), 32'd0);
      chk("strobes in reset ignored", 32'(err_a), 32'd0);
      chk("post reset rx_cnt", rxc_a, 32'd0);
      chk("post reset tx_cnt", txc_a, 32'd0);
      chk("bus released", 32'(data_a), 32'h5A);

      // ---- protocol monitor
      for (int k = 0; k < 5; k++) begin
         {oe_a, rd_a, wr_a} = epat[k];
         tick();
         oe_a = 1'b1; rd_a = 1'b1; wr_a = 1'b1;
         chk("err set", 32'(err_a), 32'(eexp[k]));
         tick();
         chk("err sticky", 32'(err_a), 32'(eexp[k]));
         rst_a = 1'b1;
         tick();
         rst_a = 1'b0;
         tick();
         chk("err cleared", 32'(err_a), 32'd0);
      end

      // ---- 32-bit byte enables
      wr_b = 1'b0; tbd_b = 32'h44332211; tbbe_b = 4'b0101;
      tick();
      wr_b = 1'b1;
      chk("ew2 out_valid", 32'(hov_b), 32'd1);
      chk("ew2 data", hod_b, 32'h44332211);
      chk("ew2 be", 32'(hob_b), 32'h5);
      chk("ew2 bytes", txc_b, 32'd2);
      wr_b = 1'b0; tbbe_b = 4'b0000; tbd_b = 32'h55667788;
      tick();
      wr_b = 1'b1;
      chk("ew2 be0 bytes", txc_b, 32'd2);
      hor_b = 1'b1;
      tick();
      hor_b = 1'b0;
      chk("ew2 be0 not stored", 32'(hov_b), 32'd0);
      hiv_b = 1'b1; hid_b = 32'hDEADBEEF; hib_b = 4'b0000;
      tick();
      chk("ew2 rx be0 dropped", 32'(rxf_b), 32'd1);
      hid_b = 32'hCAFEF00D; hib_b = 4'b1000;
      tick();
      hiv_b = 1'b0;
      chk("ew2 rx stored", 32'(rxf_b), 32'd0);
      oe_b = 1'b0;
      #1;
      chk("ew2 rx bus data", data_b, 32'hCAFEF00D);
      chk("ew2 rx bus be", 32'(be_b), 32'h8);
      rd_b = 1'b0;
      tick();
      rd_b = 1'b1; oe_b = 1'b1;
      chk("ew2 rx empty", 32'(rxf_b), 32'd1);
      chk("ew2 rx count", rxc_b, 32'd1);

      // ---- randomized traffic on instance B against the queue model
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      rxq.delete(); txq.delete();
      rxf_m = 1'b1; txe_m = 1'b1; err_m = 1'b0; rxc_m = 0; txc_m = 0;
      for (int c = 0; c < 1200; c++) begin
         int mode;
         int ph;
         ph   = (c / 100) % 2;
         mode = int'($urandom_range(0, 9));
         oe_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
         if (mode <= 3) begin
            oe_b = 1'b0;
            rd_b = ($urandom_range(0, 3) == 0);
         end else if (mode <= 6) begin
            wr_b = 1'b0;
         end else if (mode == 7) begin
            oe_b = 1'b0;
         end
         if ($urandom_range(0, 299) == 0) begin
            oe_b = 1'b1; rd_b = 1'b0;
         end
         tbd_b  = $urandom;
         tbbe_b = 4'($urandom_range(0, 15));
         hiv_b  = ($urandom_range(0, 9) < ((ph == 1) ? 3 : 8));
         hid_b  = $urandom;
         hib_b  = 4'($urandom_range(0, 15));
         hor_b  = ($urandom_range(0, 9) < ((ph == 1) ? 8 : 2));
         #1;
         pop_m = !rd_b && !rxf_m;
         rdy_m = (rxq.size() < RXD_B) || pop_m;
         chk("rnd in_ready", 32'(hir_b), 32'(rdy_m));
         if (!oe_b) begin
            chk("rnd bus data", data_b, (rxq.size() != 0) ? rxq[0].d : 32'd0);
            chk("rnd bus be", 32'(be_b), (rxq.size() != 0) ? 32'(rxq[0].be) : 32'd0);
         end
         chk("rnd out_valid", 32'(hov_b), 32'(txq.size() != 0));
         if (txq.size() != 0) begin
            chk("rnd out data", hod_b, txq[0].d);
            chk("rnd out be", 32'(hob_b), 32'(txq[0].be));
         end
         err_m = err_m | (!rd_b && oe_b) | (!rd_b && !wr_b) | (!wr_b && !oe_b);
         if (pop_m) begin
            tmp = rxq.pop_front();
            rxc_m++;
         end
         if (hiv_b && rdy_m && (hib_b != 4'd0)) rxq.push_back(word_t'{hid_b, hib_b});
         if (hor_b && (txq.size() != 0)) tmp = txq.pop_front();
         if (!wr_b && !txe_m && (tbbe_b != 4'd0)) begin
            txq.push_back(word_t'{tbd_b, tbbe_b});
            txc_m += $countones(tbbe_b);
         end
         rxf_m = (rxq.size() == 0);
         txe_m = (txq.size() > TXD_B - 1 - MARG_B);
         tick();
         chk("rnd rxf_n", 32'(rxf_b), 32'(rxf_m));
         chk("rnd txe_n", 32'(txe_b), 32'(txe_m));
         chk("rnd err", 32'(err_b), 32'(err_m));
         chk("rnd rx count", rxc_b, rxc_m);
         chk("rnd tx bytes", txc_b, txc_m);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
